// File: rtl/raytrace_pkg.sv
// Shared types and constants for the ray-trace pixel pipeline.
package raytrace_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 10;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 12;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/pixel_shader.sv
// Combinational shading function: maps a pixel coordinate to an RGB444 colour.
module pixel_shader
  import raytrace_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] colour
);

  assign colour = {x[9:6], y[8:5], x[5:2] ^ y[4:1]};

endmodule

// File: rtl/thread_receiver.sv
// Accepts one pixel coordinate at a time, shades it over PROC_CYCLES cycles
// and writes the colour to a linear framebuffer with ready backpressure.
module thread_receiver
  import raytrace_pkg::*;
#(
  parameter int H_RES       = raytrace_pkg::H_RES,
  parameter int V_RES       = raytrace_pkg::V_RES,
  parameter int PROC_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               valid,
  output logic               ray_core_free,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               fb_ready,
  output logic               frame_done,
  output logic               range_err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0] fb_data_q, fb_data_d;
  logic               last_q, last_d;
  logic               free_q, free_d;
  logic               we_q, we_d;
  logic               frame_done_q, frame_done_d;
  logic               range_err_q, range_err_d;

  logic [COLOR_W-1:0] shade;
  logic               out_of_range;
  logic               drop;

  pixel_shader u_shader (
    .x      (pixel_x),
    .y      (pixel_y),
    .colour (shade)
  );

  assign out_of_range = (32'(pixel_x) >= 32'(H_RES)) || (32'(pixel_y) >= 32'(V_RES));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    last_d       = last_q;
    range_err_d  = range_err_q;
    frame_done_d = 1'b0;
    drop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && free_q) begin
          if (out_of_range) begin
            range_err_d = 1'b1;
            drop        = 1'b1;
          end else begin
            state_d   = CALC;
            cnt_d     = CNT_W'(PROC_CYCLES - 1);
            fb_addr_d = ADDR_W'(pixel_y) * ADDR_W'(H_RES) + ADDR_W'(pixel_x);
            fb_data_d = shade;
            last_d    = (pixel_x == COORD_W'(H_RES - 1)) && (pixel_y == COORD_W'(V_RES - 1));
          end
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITE: begin
        if (fb_ready) begin
          state_d      = IDLE;
          frame_done_d = last_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // A dropped offer still costs one busy cycle before the next acceptance.
    free_d = (state_d == IDLE) && !drop;
    we_d   = (state_d == WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      last_q       <= 1'b0;
      free_q       <= 1'b0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      last_q       <= last_d;
      free_q       <= free_d;
      we_q         <= we_d;
      frame_done_q <= frame_done_d;
      range_err_q  <= range_err_d;
    end
  end

  assign ray_core_free = free_q;
  assign fb_we         = we_q;
  assign fb_addr       = fb_addr_q;
  assign fb_data       = fb_data_q;
  assign frame_done    = frame_done_q;
  assign range_err     = range_err_q;

endmodule

// File: tb/tb_thread_receiver.sv
// Directed self-checking bench for thread_receiver with default parameters.
module tb_thread_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        valid;
  logic        ray_core_free;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_ready;
  logic        frame_done;
  logic        range_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  thread_receiver dut (
    .clk           (clk),
    .rst           (rst),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .valid         (valid),
    .ray_core_free (ray_core_free),
    .fb_we         (fb_we),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .fb_ready      (fb_ready),
    .frame_done    (frame_done),
    .range_err     (range_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; pixel_x = '0; pixel_y = '0; fb_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ray_core_free, fb_we, frame_done, range_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got free/we/done/err=%b required 0000",
               {ray_core_free, fb_we, frame_done, range_err});
    end
    checks++;
    if (fb_addr !== 19'd0 || fb_data !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_bus: got addr=%0d data=%h required 0/000", fb_addr, fb_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ray_core_free !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_free: got %b required 1", ray_core_free);
    end
  endtask

  task automatic test_basic();
    logic exp_we, exp_free;
    pixel_x = 10'd3; pixel_y = 10'd2; valid = 1'b1; fb_ready = 1'b1;
    tick();
    valid = 1'b0;
    checks++;
    if (ray_core_free !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_busy: got free=%b required 0", ray_core_free);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_we   = (i == 4);
      exp_free = (i == 5);
      checks++;
      if (fb_we !== exp_we || ray_core_free !== exp_free) begin
        errors++;
        $display("[TB] FAIL basic_timing N+%0d: got we=%b free=%b required we=%b free=%b",
                 i, fb_we, ray_core_free, exp_we, exp_free);
      end
      if (exp_we) begin
        checks++;
        if (fb_addr !== 19'd1283 || fb_data !== 12'h001) begin
          errors++;
          $display("[TB] FAIL basic_payload: got addr=%0d data=%h required 1283/001", fb_addr, fb_data);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    pixel_x = 10'd10; pixel_y = 10'd10; valid = 1'b1; fb_ready = 1'b0;
    tick();
    valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (fb_we !== 1'b1 || ray_core_free !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_enter_write: got we=%b free=%b required 1/0", fb_we, ray_core_free);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (fb_we !== 1'b1 || ray_core_free !== 1'b0 || fb_addr !== 19'd6410 || fb_data !== 12'h007) begin
        errors++;
        $display("[TB] FAIL bp_hold %0d: got we=%b free=%b addr=%0d data=%h required 1/0/6410/007",
                 i, fb_we, ray_core_free, fb_addr, fb_data);
      end
    end
    fb_ready = 1'b1;
    tick();
    checks++;
    if (fb_we !== 1'b0 || ray_core_free !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got we=%b free=%b required 0/1", fb_we, ray_core_free);
    end
  endtask

  task automatic test_range();
    pixel_x = 10'd640; pixel_y = 10'd0; valid = 1'b1; fb_ready = 1'b1;
    tick();
    valid = 1'b0;
    checks++;
    if (range_err !== 1'b1 || ray_core_free !== 1'b0 || fb_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL range_accept: got err=%b free=%b we=%b required 1/0/0",
               range_err, ray_core_free, fb_we);
    end
    tick();
    checks++;
    if (ray_core_free !== 1'b1) begin
      errors++;
      $display("[TB] FAIL range_recover: got free=%b required 1", ray_core_free);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (fb_we !== 1'b0 || range_err !== 1'b1) begin
        errors++;
        $display("[TB] FAIL range_sticky %0d: got we=%b err=%b required 0/1", i, fb_we, range_err);
      end
    end
  endtask

  task automatic test_last_pixel();
    logic exp_we, exp_done;
    pixel_x = 10'd639; pixel_y = 10'd479; valid = 1'b1; fb_ready = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_we   = (i == 4);
      exp_done = (i == 5);
      checks++;
      if (fb_we !== exp_we || frame_done !== exp_done) begin
        errors++;
        $display("[TB] FAIL last_timing N+%0d: got we=%b done=%b required we=%b done=%b",
                 i, fb_we, frame_done, exp_we, exp_done);
      end
      if (exp_we) begin
        checks++;
        if (fb_addr !== 19'd307199 || fb_data !== 12'h9E0) begin
          errors++;
          $display("[TB] FAIL last_payload: got addr=%0d data=%h required 307199/9e0", fb_addr, fb_data);
        end
      end
    end
    checks++;
    if (range_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL last_err_kept: got err=%b required 1", range_err);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_we;
    pixel_x = 10'd5; pixel_y = 10'd0; valid = 1'b1; fb_ready = 1'b1;
    tick();
    pixel_x = 10'd6;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 6) valid = 1'b0;
      exp_we = (i == 4) || (i == 10);
      checks++;
      if (fb_we !== exp_we) begin
        errors++;
        $display("[TB] FAIL b2b_we N+%0d: got %b required %b", i, fb_we, exp_we);
      end
      if (exp_we) begin
        checks++;
        if (fb_addr !== ((i == 4) ? 19'd5 : 19'd6)) begin
          errors++;
          $display("[TB] FAIL b2b_addr N+%0d: got %0d required %0d", i, fb_addr, (i == 4) ? 5 : 6);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic exp_we;
    pixel_x = 10'd20; pixel_y = 10'd3; valid = 1'b1; fb_ready = 1'b1;
    tick();
    valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({ray_core_free, fb_we, frame_done, range_err} !== 4'b0000 || fb_addr !== 19'd0 || fb_data !== 12'd0) begin
      errors++;
      $display("[TB] FAIL abort_reset: got free/we/done/err=%b addr=%0d data=%h required 0000/0/000",
               {ray_core_free, fb_we, frame_done, range_err}, fb_addr, fb_data);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (fb_we !== 1'b0 || ray_core_free !== 1'b1) begin
        errors++;
        $display("[TB] FAIL abort_no_write %0d: got we=%b free=%b required 0/1", i, fb_we, ray_core_free);
      end
    end
    pixel_x = 10'd7; pixel_y = 10'd1; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_we = (i == 4);
      checks++;
      if (fb_we !== exp_we) begin
        errors++;
        $display("[TB] FAIL abort_next_we N+%0d: got %b required %b", i, fb_we, exp_we);
      end
      if (exp_we) begin
        checks++;
        if (fb_addr !== 19'd647 || fb_data !== 12'h001) begin
          errors++;
          $display("[TB] FAIL abort_next_payload: got addr=%0d data=%h required 647/001", fb_addr, fb_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_range();
    test_last_pixel();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/thread_receiver.md
THREAD_RECEIVER -- requirements
Module: thread_receiver

Interface
REQ-001 The parameter H_RES SHALL default to 640 and set the horizontal pixel count.
REQ-002 The parameter V_RES SHALL default to 480 and set the vertical pixel count.
REQ-003 The parameter PROC_CYCLES SHALL default to 4 and set the shading latency in cycles, with a legal range of 1..15.
REQ-004 The port clk SHALL be a 1-bit input and the single clock; all logic SHALL be on its rising edge.
REQ-005 The port rst SHALL be a 1-bit input: synchronous, active-high reset.
REQ-006 The port pixel_x SHALL be a 10-bit input carrying the offered pixel column.
REQ-007 The port pixel_y SHALL be a 10-bit input carrying the offered pixel row.
REQ-008 The port valid SHALL be a 1-bit input; high means pixel_x/pixel_y hold a valid offer.
REQ-009 The port ray_core_free SHALL be a 1-bit registered output; high means the block accepts an offer this cycle.
REQ-010 The port fb_we SHALL be a 1-bit output: framebuffer write request.
REQ-011 The port fb_addr SHALL be a 19-bit output: linear framebuffer address.
REQ-012 The port fb_data SHALL be a 12-bit output: RGB444 colour.
REQ-013 The port fb_ready SHALL be a 1-bit input; high means the framebuffer accepts the write this cycle.
REQ-014 The port frame_done SHALL be a 1-bit output: one-cycle pulse when the last pixel is written.
REQ-015 The port range_err SHALL be a 1-bit output: sticky flag for an out-of-range offer.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, CALC and WRITE; ray_core_free SHALL be 1 only in IDLE.
REQ-017 A transfer SHALL occur on a rising edge where valid=1 and ray_core_free=1; pixel_x/pixel_y SHALL be captured on that edge, and valid SHALL be ignored while ray_core_free=0.
REQ-018 On an in-range transfer the FSM SHALL go IDLE->CALC and stay in CALC for exactly PROC_CYCLES cycles, timed by a 4-bit down-counter.
REQ-019 fb_addr SHALL equal y*H_RES + x, computed from the captured coordinates with 19-bit unsigned arithmetic and held stable while fb_we=1.
REQ-020 fb_data SHALL be {x[9:6], y[8:5], x[5:2]^y[4:1]} of the captured coordinates, held stable while fb_we=1.
REQ-021 In WRITE, fb_we SHALL be 1; the FSM SHALL stay in WRITE until fb_ready=1, then return to IDLE on the next edge.
REQ-022 Latency: with transfer on edge N and fb_ready=1, fb_we SHALL be high for exactly one cycle beginning after edge N+PROC_CYCLES, and ray_core_free SHALL be 1 after edge N+PROC_CYCLES+1.
REQ-023 An offer with x>=H_RES or y>=V_RES SHALL be accepted and dropped: no CALC, no write, range_err set to 1, and the FSM back in IDLE one cycle later.
REQ-024 frame_done SHALL pulse for one cycle, on the cycle after the completed write (fb_we & fb_ready) of pixel (H_RES-1, V_RES-1).
REQ-025 range_err SHALL clear only on rst.
REQ-026 fb_ready=1 outside WRITE SHALL have no effect.

Reset
REQ-027 While rst=1, the block SHALL hold: state=IDLE, ray_core_free=0, fb_we=0, fb_addr=0, fb_data=0, frame_done=0, range_err=0, counter=0.
REQ-028 ray_core_free SHALL rise on the first edge after rst falls.
REQ-029 Reset asserted in CALC or WRITE SHALL abort the pixel without a write and without a frame_done pulse.

Structure
REQ-030 H_RES, V_RES, the coordinate width (10), the address width (19), the colour width (12) and the state encodings SHALL live in the shared package raytrace_pkg.
REQ-031 The colour function SHALL be a combinational sub-module pixel_shader (inputs x, y; output colour) so it can later be replaced by real shading.

Verification
REQ-032 Reset then offer x=3, y=2, fb_ready=1 -> fb_we single cycle, fb_addr=1283, fb_data per REQ-020, ray_core_free back high at N+5.
REQ-033 Offer (10,10) with fb_ready=0 held for 6 cycles -> fb_we high for 7 cycles, address and data stable, ray_core_free stays 0 throughout.
REQ-034 Offer x=640, y=0 -> no fb_we, range_err=1, ray_core_free=1 two cycles after transfer, range_err persists until rst.
REQ-035 Offer (639,479) with fb_ready=1 -> fb_addr=307199 and frame_done high exactly one cycle, the cycle after the write.
REQ-036 Hold valid=1 while busy, changing pixel_x from 5 to 6 -> only the captured value 5 is written; 6 is accepted at the next IDLE.
REQ-037 Assert rst during CALC -> no fb_we and outputs at reset values; the next offer after reset is processed normally.
